// File: rtl/sync_fifo_param.sv
// Parametrised single-clock show-ahead FIFO with fill count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow and synchronous flush.
module sync_fifo_param #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 4,
  parameter int unsigned AF_LVL = 14,
  parameter int unsigned AE_LVL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DWIDTH-1:0] datain,
  input  logic              wr,
  input  logic              rd,
  output logic [DWIDTH-1:0] dataout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AWIDTH:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned   DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] AF_C = (AWIDTH+1)'(AF_LVL);
  localparam logic [AWIDTH:0] AE_C = (AWIDTH+1)'(AE_LVL);

  logic [AWIDTH:0]   wp_q, wp_d;
  logic [AWIDTH:0]   rp_q, rp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wr_ok, rd_ok;
  logic [AWIDTH:0]   cnt;
  logic              full_w, empty_w;
  logic [DWIDTH-1:0] mem_q [DEPTH];

  // Extra pointer MSB is a wrap bit: equal low bits with differing MSBs means full.
  assign cnt     = wp_q - rp_q;
  assign full_w  = (wp_q[AWIDTH-1:0] == rp_q[AWIDTH-1:0]) && (wp_q[AWIDTH] != rp_q[AWIDTH]);
  assign empty_w = (wp_q == rp_q);

  assign count        = cnt;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (cnt >= AF_C);
  assign almost_empty = (cnt <= AE_C);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign dataout      = mem_q[rp_q[AWIDTH-1:0]];

  always_comb begin
    wr_ok = wr & ~full_w & ~flush;
    rd_ok = rd & ~empty_w & ~flush;
    wp_d  = wp_q;
    rp_d  = rp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (wr_ok) wp_d = wp_q + 1'b1;
      if (rd_ok) rp_d = rp_q + 1'b1;
      ovf_d = ovf_q | (wr & full_w);
      unf_d = unf_q | (rd & empty_w);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage is deliberately left out of reset; empty masks its contents.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wp_q[AWIDTH-1:0]] <= datain;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed checks of sync_fifo_param in two configurations
// against a queue-based reference model.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 8-bit x 16, AF=14, AE=2
  logic       a_flush = 1'b0, a_wr = 1'b0, a_rd = 1'b0;
  logic [7:0] a_datain = '0, a_dataout;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [4:0] a_count;

  // Instance B: 32-bit x 64, AF=60, AE=4
  logic        b_flush = 1'b0, b_wr = 1'b0, b_rd = 1'b0;
  logic [31:0] b_datain = '0, b_dataout;
  logic        b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [6:0]  b_count;

  sync_fifo_param #(.DWIDTH(8), .AWIDTH(4), .AF_LVL(14), .AE_LVL(2)) u_dut_a (
    .clk(clk), .rst(rst), .flush(a_flush), .datain(a_datain), .wr(a_wr), .rd(a_rd),
    .dataout(a_dataout), .full(a_full), .empty(a_empty), .almost_full(a_af),
    .almost_empty(a_ae), .count(a_count), .overflow(a_ovf), .underflow(a_unf)
  );

  sync_fifo_param #(.DWIDTH(32), .AWIDTH(6), .AF_LVL(60), .AE_LVL(4)) u_dut_b (
    .clk(clk), .rst(rst), .flush(b_flush), .datain(b_datain), .wr(b_wr), .rd(b_rd),
    .dataout(b_dataout), .full(b_full), .empty(b_empty), .almost_full(b_af),
    .almost_empty(b_ae), .count(b_count), .overflow(b_ovf), .underflow(b_unf)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  bit ova = 0, una = 0, ovb = 0, unb = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int depth_of(input int inst);
    return (inst == 0) ? 16 : 64;
  endfunction

  function automatic int af_of(input int inst);
    return (inst == 0) ? 14 : 60;
  endfunction

  function automatic int ae_of(input int inst);
    return (inst == 0) ? 2 : 4;
  endfunction

  task automatic model_clear();
    qa.delete();
    qb.delete();
    ova = 0; una = 0; ovb = 0; unb = 0;
  endtask

  // One clock of the reference: decisions use the occupancy before the edge.
  task automatic model_step(input int inst, input bit fl, input bit w, input bit r,
                            input logic [31:0] d);
    int  n;
    bit  isf, ise;
    n   = (inst == 0) ? qa.size() : qb.size();
    isf = (n == depth_of(inst));
    ise = (n == 0);
    if (inst == 0) begin
      if (fl) begin
        qa.delete(); ova = 0; una = 0;
      end else begin
        if (w && isf) ova = 1;
        if (r && ise) una = 1;
        if (r && !ise) void'(qa.pop_front());
        if (w && !isf) qa.push_back(d & 32'hFF);
      end
    end else begin
      if (fl) begin
        qb.delete(); ovb = 0; unb = 0;
      end else begin
        if (w && isf) ovb = 1;
        if (r && ise) unb = 1;
        if (r && !ise) void'(qb.pop_front());
        if (w && !isf) qb.push_back(d);
      end
    end
  endtask

  task automatic check_dut(input int inst);
    int          n;
    logic [31:0] head;
    string       p;
    if (inst == 0) begin
      p = "a"; n = qa.size(); head = (n > 0) ? qa[0] : '0;
      chk({p, ".count"}, 32'(a_count), 32'(n));
      chk({p, ".empty"}, 32'(a_empty), 32'(n == 0));
      chk({p, ".full"}, 32'(a_full), 32'(n == depth_of(0)));
      chk({p, ".almost_full"}, 32'(a_af), 32'(n >= af_of(0)));
      chk({p, ".almost_empty"}, 32'(a_ae), 32'(n <= ae_of(0)));
      chk({p, ".overflow"}, 32'(a_ovf), 32'(ova));
      chk({p, ".underflow"}, 32'(a_unf), 32'(una));
      if (n > 0) chk({p, ".dataout"}, 32'(a_dataout), head);
    end else begin
      p = "b"; n = qb.size(); head = (n > 0) ? qb[0] : '0;
      chk({p, ".count"}, 32'(b_count), 32'(n));
      chk({p, ".empty"}, 32'(b_empty), 32'(n == 0));
      chk({p, ".full"}, 32'(b_full), 32'(n == depth_of(1)));
      chk({p, ".almost_full"}, 32'(b_af), 32'(n >= af_of(1)));
      chk({p, ".almost_empty"}, 32'(b_ae), 32'(n <= ae_of(1)));
      chk({p, ".overflow"}, 32'(b_ovf), 32'(ovb));
      chk({p, ".underflow"}, 32'(b_unf), 32'(unb));
      if (n > 0) chk({p, ".dataout"}, b_dataout, head);
    end
  endtask

  task automatic cycle(input int inst, input bit fl, input bit w, input bit r,
                       input logic [31:0] d);
    if (inst == 0) begin
      a_flush = fl; a_wr = w; a_rd = r; a_datain = d[7:0];
    end else begin
      b_flush = fl; b_wr = w; b_rd = r; b_datain = d;
    end
    @(posedge clk);
    model_step(inst, fl, w, r, d);
    #1;
    check_dut(inst);
    a_flush = 1'b0; a_wr = 1'b0; a_rd = 1'b0;
    b_flush = 1'b0; b_wr = 1'b0; b_rd = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  // Reset dropped between edges must take effect before the next clock.
  task automatic mid_reset(input int inst);
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    check_dut(inst);
    release_reset();
  endtask

  task automatic random_run(input int inst, input int ncyc);
    int pw;
    bit w, r, fl;
    for (int i = 0; i < ncyc; i++) begin
      pw = ((i / 40) % 2 == 0) ? 75 : 25;
      w  = ($urandom_range(99) < pw);
      r  = ($urandom_range(99) < (100 - pw));
      fl = ($urandom_range(149) == 0);
      cycle(inst, fl, w, r, $urandom);
    end
  endtask

  task automatic directed(input int inst);
    int d;
    d = depth_of(inst);
    for (int i = 0; i < d; i++) cycle(inst, 0, 1, 0, 32'(i));
    for (int i = 0; i < d; i++) cycle(inst, 0, 0, 1, 32'h0);
    for (int i = 0; i < d; i++) cycle(inst, 0, 1, 0, 32'(i + 'h40));
    cycle(inst, 0, 1, 1, 32'hEE);
    for (int i = 0; i < 20; i++) cycle(inst, 0, (i % 2) == 0, (i % 2) == 1, 32'(i + 'h80));
    for (int i = 0; i < d; i++) cycle(inst, 0, 0, 1, 32'h0);
    cycle(inst, 0, 0, 1, 32'h0);
    cycle(inst, 0, 1, 1, 32'hA5);
    for (int i = 0; i < 5; i++) cycle(inst, 0, 1, 0, 32'(i + 'h10));
    cycle(inst, 1, 1, 0, 32'h77);
    cycle(inst, 0, 1, 0, 32'h3C);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_clear();
    #12;
    release_reset();
    repeat (2) cycle(0, 0, 0, 0, 32'h0);

    directed(0);
    random_run(0, 400);
    for (int i = 0; i < 9; i++) cycle(0, 0, 1, 0, 32'(i + 'h20));
    mid_reset(0);

    directed(1);
    random_run(1, 600);
    for (int i = 0; i < 9; i++) cycle(1, 0, 1, 0, 32'(i + 'hDEAD0000));
    mid_reset(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
